cdu_count_rx: RTL and testbench

//  AGC-side receiver for the CDU angle-increment interface: accepts the +/- pulse trains
//  (PCDU/MCDU) that a CDU channel emits as its read counter tracks the resolver angle.

---
 rtl/cdu_count_rx_pkg.sv | 29 ++
 rtl/cdu_count_rx_if.sv | 28 ++
 rtl/cdu_count_rx_pulse_filter.sv | 68 ++++++
 rtl/cdu_count_rx.sv | 84 ++++++++
 tb/tb_cdu_count_rx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdu_count_rx_pkg.sv
// Shared types and constants for the CDU angle-increment receiver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cdu_count_rx_pkg;

  localparam int ANGLE_W  = 15;
  localparam int PEND_W   = 4;
  localparam int PEND_MAX = (1 << (PEND_W - 1)) - 1;

  typedef logic signed [PEND_W-1:0] pend_t;
  typedef logic signed [1:0]        step_t;

  // IDLE: still counting high samples; HELD: pulse already counted, waiting for low
  typedef enum logic {
    FILT_IDLE = 1'b0,
    FILT_HELD = 1'b1
  } filt_state_e;

  // -1/0/+1 according to the sign of a pending count
  function automatic step_t sign(input pend_t v);
    if (v > 0) begin
      return 2'sb01;
    end else if (v < 0) begin
      return 2'sb11;
    end
    return 2'sb00;
  endfunction

endpackage

// File: rtl/cdu_count_rx_if.sv
// CDU pulse inputs, service/zero controls and angle/pending outputs of one gimbal channel.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are free-running and SVC is a strobe.
interface cdu_count_rx_if #(
  parameter int ANGLE_W = cdu_count_rx_pkg::ANGLE_W
);
  import cdu_count_rx_pkg::*;

  logic               PCDU;
  logic               MCDU;
  logic               SVC;
  logic               CCDUZ;
  logic [ANGLE_W-1:0] ANGLE;
  pend_t              PEND;
  logic               CNT_UPD;
  logic               PEND_OVF;

  modport master (
    output PCDU, MCDU, SVC, CCDUZ,
    input  ANGLE, PEND, CNT_UPD, PEND_OVF
  );

  modport slave (
    input  PCDU, MCDU, SVC, CCDUZ,
    output ANGLE, PEND, CNT_UPD, PEND_OVF
  );

endinterface

// File: rtl/cdu_count_rx_pulse_filter.sv
// Synchronizes one CDU pulse line and emits a single-cycle qual per pulse at least MIN_W samples wide.
// Latency: input rise -> qual after SYNC_ST+MIN_W-1 cycles.
// Backpressure: none; a pulse held high counts once and must drop low before it can requalify.
module cdu_count_rx_pulse_filter
  import cdu_count_rx_pkg::*;
#(
  parameter int SYNC_ST = 2,
  parameter int MIN_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic qual
);

  localparam int            CW   = $clog2(MIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(MIN_W - 1);

  logic [SYNC_ST-1:0] sync;
  logic               smp;
  logic [CW-1:0]      cnt, cnt_nxt;
  filt_state_e        st, st_nxt;

  assign smp = sync[SYNC_ST-1];

  // Metastability chain for the asynchronous pulse input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_ST; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // High-sample counter and IDLE/HELD state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= FILT_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Count consecutive high samples; qualify on the sample that reaches MIN_W
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    qual    = 1'b0;
    if (!smp) begin
      st_nxt  = FILT_IDLE;
      cnt_nxt = '0;
    end else if (st == FILT_IDLE) begin
      if (cnt == LAST) begin
        qual    = 1'b1;
        st_nxt  = FILT_HELD;
        cnt_nxt = CW'(MIN_W);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdu_count_rx.sv
// AGC-side CDU receiver: nets filtered +/- pulses into a saturating pending count, drained one unit per SVC into ANGLE.
// Latency: qualified pulse -> PEND next edge; SVC with PEND!=0 -> ANGLE next edge, CNT_UPD the cycle after that edge.
// Backpressure: none; pulses beyond +/-PEND_MAX are dropped and flagged in sticky PEND_OVF.
module cdu_count_rx
  import cdu_count_rx_pkg::*;
#(
  parameter int ANGLE_W = cdu_count_rx_pkg::ANGLE_W,
  parameter int SYNC_ST = 2,
  parameter int MIN_W   = 4
) (
  input logic           CLOCKH,
  input logic           rst,
  cdu_count_rx_if.slave bus
);

  localparam int SW = PEND_W + 2;
  typedef logic signed [SW-1:0] wide_t;

  logic               p_q, m_q;
  pend_t              pend, pend_nxt;
  logic [ANGLE_W-1:0] angle, angle_nxt;
  logic               upd, ovf, ovf_hit;
  step_t              s;
  wide_t              sum_w;

  cdu_count_rx_pulse_filter #(.SYNC_ST(SYNC_ST), .MIN_W(MIN_W)) u_pflt (
    .clk  (CLOCKH),
    .rst  (rst),
    .din  (bus.PCDU),
    .qual (p_q)
  );

  cdu_count_rx_pulse_filter #(.SYNC_ST(SYNC_ST), .MIN_W(MIN_W)) u_mflt (
    .clk  (CLOCKH),
    .rst  (rst),
    .din  (bus.MCDU),
    .qual (m_q)
  );

  // Net this cycle's pulses against one serviced unit, then clamp to the pending range
  always_comb begin
    s     = bus.SVC ? sign(pend) : 2'sb00;
    sum_w = wide_t'(pend);
    if (p_q) begin
      sum_w = sum_w + wide_t'(1);
    end
    if (m_q) begin
      sum_w = sum_w - wide_t'(1);
    end
    sum_w    = sum_w - wide_t'(s);
    pend_nxt = pend_t'(sum_w);
    ovf_hit  = 1'b0;
    if (sum_w > wide_t'(PEND_MAX)) begin
      pend_nxt = pend_t'(PEND_MAX);
      ovf_hit  = 1'b1;
    end else if (sum_w < wide_t'(-PEND_MAX)) begin
      pend_nxt = pend_t'(-PEND_MAX);
      ovf_hit  = 1'b1;
    end
    // Sign-extended step added modulo 2^ANGLE_W gives the 0x7FFF<->0x0000 wrap
    angle_nxt = angle + ANGLE_W'(s);
  end

  // Datapath registers; the zero command discards that cycle's pulses and service
  always_ff @(posedge CLOCKH) begin
    if (rst || bus.CCDUZ) begin
      angle <= '0;
      pend  <= '0;
      upd   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      angle <= angle_nxt;
      pend  <= pend_nxt;
      upd   <= (s != 2'sb00);
      ovf   <= ovf | ovf_hit;
    end
  end

  assign bus.ANGLE    = angle;
  assign bus.PEND     = pend;
  assign bus.CNT_UPD  = upd;
  assign bus.PEND_OVF = ovf;

endmodule

// File: tb/tb_cdu_count_rx.sv
// Self-checking bench for cdu_count_rx: directed scenarios plus randomized traffic against a run-length model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdu_count_rx;
  import cdu_count_rx_pkg::*;

  localparam int SYNC_ST = 2;
  localparam int MIN_W   = 4;
  localparam int LAT     = SYNC_ST + MIN_W;
  localparam int AMOD    = 1 << ANGLE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdu_count_rx_if bus ();

  cdu_count_rx #(.ANGLE_W(ANGLE_W), .SYNC_ST(SYNC_ST), .MIN_W(MIN_W)) dut (
    .CLOCKH (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a pulse counts when its run of high samples reaches MIN_W,
  // and takes effect SYNC_ST edges after the sample that completed the run.
  int m_angle, m_pend, m_ovf, m_upd;
  int run_p, run_m;
  int hist_p[$];
  int hist_m[$];

  task automatic model_edge();
    int qp, qm, s, sum;
    if (rst) begin
      m_angle = 0; m_pend = 0; m_ovf = 0; m_upd = 0;
      run_p = 0; run_m = 0;
      hist_p.delete(); hist_m.delete();
      for (int i = 0; i < SYNC_ST; i++) begin
        hist_p.push_back(0);
        hist_m.push_back(0);
      end
    end else begin
      run_p = bus.PCDU ? run_p + 1 : 0;
      run_m = bus.MCDU ? run_m + 1 : 0;
      hist_p.push_back(run_p);
      hist_m.push_back(run_m);
      qp = (hist_p.pop_front() == MIN_W) ? 1 : 0;
      qm = (hist_m.pop_front() == MIN_W) ? 1 : 0;
      if (bus.CCDUZ) begin
        m_angle = 0; m_pend = 0; m_ovf = 0; m_upd = 0;
      end else begin
        s = 0;
        if (bus.SVC && m_pend > 0) s = 1;
        if (bus.SVC && m_pend < 0) s = -1;
        sum = m_pend + qp - qm - s;
        if (sum > PEND_MAX) begin
          m_pend = PEND_MAX; m_ovf = 1;
        end else if (sum < -PEND_MAX) begin
          m_pend = -PEND_MAX; m_ovf = 1;
        end else begin
          m_pend = sum;
        end
        m_angle = (m_angle + s + AMOD) % AMOD;
        m_upd   = (s != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit p, input bit m, input bit sv, input bit z);
    bus.PCDU = p; bus.MCDU = m; bus.SVC = sv; bus.CCDUZ = z;
  endtask

  task automatic clear();
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic pulse(input bit p, input bit m, input int len, input int gap, input bit sv);
    drive(p, m, sv, 0);
    repeat (len) tick();
    drive(0, 0, sv, 0);
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0);
    tick(); tick();
    n_cmp += 4;
    if (bus.ANGLE !== '0) begin n_err++; $display("FAIL reset_angle: got %0h expected 0", bus.ANGLE); end
    if (bus.PEND !== '0) begin n_err++; $display("FAIL reset_pend: got %0d expected 0", bus.PEND); end
    if (bus.CNT_UPD !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b expected 0", bus.CNT_UPD); end
    if (bus.PEND_OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", bus.PEND_OVF); end
    rst = 1'b0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      n_cmp++;
      if ($signed(bus.PEND) !== ((i >= LAT) ? 1 : 0)) begin
        n_err++;
        $display("FAIL reset_held_pulse edge %0d: got %0d expected %0d", i, $signed(bus.PEND), (i >= LAT) ? 1 : 0);
      end
    end
    drive(0, 0, 0, 0);
    repeat (8) tick();
  endtask

  task automatic test_width();
    clear();
    pulse(1, 0, 3, 8, 0);
    n_cmp++;
    if ($signed(bus.PEND) !== 0) begin n_err++; $display("FAIL width_short: got %0d expected 0", $signed(bus.PEND)); end
    pulse(1, 0, 4, 8, 0);
    n_cmp++;
    if ($signed(bus.PEND) !== 1) begin n_err++; $display("FAIL width_min: got %0d expected 1", $signed(bus.PEND)); end
    clear();
    pulse(1, 0, 40, 10, 0);
    n_cmp++;
    if ($signed(bus.PEND) !== 1) begin n_err++; $display("FAIL width_long: got %0d expected 1", $signed(bus.PEND)); end
  endtask

  task automatic test_service();
    int upds = 0;
    clear();
    repeat (3) pulse(1, 0, 5, 3, 0);
    n_cmp++;
    if ($signed(bus.PEND) !== 3) begin n_err++; $display("FAIL svc_pend_pre: got %0d expected 3", $signed(bus.PEND)); end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 0);
      tick();
      upds += int'(bus.CNT_UPD);
      n_cmp += 2;
      if (bus.ANGLE !== ANGLE_W'((k > 3) ? 3 : k)) begin
        n_err++; $display("FAIL svc_angle %0d: got %0d expected %0d", k, bus.ANGLE, (k > 3) ? 3 : k);
      end
      if (bus.CNT_UPD !== ((k <= 3) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL svc_upd %0d: got %b expected %b", k, bus.CNT_UPD, k <= 3);
      end
      drive(0, 0, 0, 0);
      tick();
      upds += int'(bus.CNT_UPD);
    end
    n_cmp += 2;
    if (upds !== 3) begin n_err++; $display("FAIL svc_upd_total: got %0d expected 3", upds); end
    if ($signed(bus.PEND) !== 0) begin n_err++; $display("FAIL svc_pend_post: got %0d expected 0", $signed(bus.PEND)); end
  endtask

  task automatic test_wrap();
    clear();
    pulse(0, 1, 5, 8, 0);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    n_cmp++;
    if (bus.ANGLE !== 15'h7FFF) begin n_err++; $display("FAIL wrap_down: got %0h expected 7fff", bus.ANGLE); end
    pulse(1, 0, 5, 8, 1);
    n_cmp++;
    if (bus.ANGLE !== 15'h0000) begin n_err++; $display("FAIL wrap_up: got %0h expected 0", bus.ANGLE); end
    repeat (2) pulse(0, 1, 5, 3, 0);
    repeat (2) begin drive(0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 0);
    n_cmp += 3;
    if (bus.ANGLE !== 15'h7FFE) begin n_err++; $display("FAIL wrap_minus2: got %0h expected 7ffe", bus.ANGLE); end
    if ($signed(bus.PEND) !== 0) begin n_err++; $display("FAIL wrap_pend: got %0d expected 0", $signed(bus.PEND)); end
    if (bus.ANGLE !== ANGLE_W'(m_angle)) begin n_err++; $display("FAIL wrap_model: got %0h expected %0h", bus.ANGLE, m_angle); end
  endtask

  task automatic test_saturation();
    clear();
    repeat (9) pulse(1, 0, 5, 2, 0);
    tick();
    n_cmp += 2;
    if ($signed(bus.PEND) !== 7) begin n_err++; $display("FAIL sat_pend: got %0d expected 7", $signed(bus.PEND)); end
    if (bus.PEND_OVF !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b expected 1", bus.PEND_OVF); end
    clear();
    repeat (2) pulse(1, 0, 5, 3, 0);
    pulse(1, 1, 5, 8, 0);
    n_cmp += 2;
    if ($signed(bus.PEND) !== 2) begin n_err++; $display("FAIL cancel_pend: got %0d expected 2", $signed(bus.PEND)); end
    if (bus.PEND_OVF !== 1'b0) begin n_err++; $display("FAIL cancel_ovf: got %b expected 0", bus.PEND_OVF); end
  endtask

  task automatic test_ccduz();
    clear();
    repeat (4658) begin
      drive(1, 0, 1, 0);
      repeat (4) tick();
      drive(0, 0, 1, 0);
      tick();
    end
    repeat (10) tick();
    drive(0, 0, 0, 0);
    n_cmp++;
    if (bus.ANGLE !== 15'h1232) begin n_err++; $display("FAIL zero_ramp: got %0h expected 1232", bus.ANGLE); end
    repeat (9) pulse(1, 0, 5, 2, 0);
    tick();
    repeat (2) begin drive(0, 0, 1, 0); tick(); end
    n_cmp += 3;
    if (bus.ANGLE !== 15'h1234) begin n_err++; $display("FAIL zero_pre_angle: got %0h expected 1234", bus.ANGLE); end
    if ($signed(bus.PEND) !== 5) begin n_err++; $display("FAIL zero_pre_pend: got %0d expected 5", $signed(bus.PEND)); end
    if (bus.PEND_OVF !== 1'b1) begin n_err++; $display("FAIL zero_pre_ovf: got %b expected 1", bus.PEND_OVF); end
    drive(0, 0, 1, 1);
    tick();
    n_cmp += 4;
    if (bus.ANGLE !== '0) begin n_err++; $display("FAIL zero_angle: got %0h expected 0", bus.ANGLE); end
    if (bus.PEND !== '0) begin n_err++; $display("FAIL zero_pend: got %0d expected 0", $signed(bus.PEND)); end
    if (bus.PEND_OVF !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b expected 0", bus.PEND_OVF); end
    if (bus.CNT_UPD !== 1'b0) begin n_err++; $display("FAIL zero_upd: got %b expected 0", bus.CNT_UPD); end
    drive(0, 0, 0, 0);
    tick();
    n_cmp++;
    if (bus.CNT_UPD !== 1'b0) begin n_err++; $display("FAIL zero_upd_next: got %b expected 0", bus.CNT_UPD); end
    // Zero command while a pulse is mid-qualification: the pulse still counts afterwards
    drive(1, 0, 0, 0); repeat (2) tick();
    drive(1, 0, 0, 1); repeat (2) tick();
    drive(1, 0, 0, 0); repeat (2) tick();
    drive(0, 0, 0, 0); repeat (8) tick();
    n_cmp++;
    if ($signed(bus.PEND) !== 1) begin n_err++; $display("FAIL zero_midpulse: got %0d expected 1", $signed(bus.PEND)); end
  endtask

  task automatic test_random();
    bit p_lvl = 0, m_lvl = 0;
    int p_left = 0, m_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (p_left == 0) begin p_lvl = ~p_lvl; p_left = p_lvl ? $urandom_range(1, 8) : $urandom_range(1, 6); end
      if (m_left == 0) begin m_lvl = ~m_lvl; m_left = m_lvl ? $urandom_range(1, 8) : $urandom_range(1, 6); end
      p_left--; m_left--;
      rst = ($urandom_range(0, 999) == 0);
      drive(p_lvl, m_lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 249) == 0);
      tick();
      n_cmp += 4;
      if (bus.ANGLE !== ANGLE_W'(m_angle)) begin n_err++; $display("FAIL rand_angle c%0d: got %0h expected %0h", c, bus.ANGLE, m_angle); end
      if ($signed(bus.PEND) !== m_pend) begin n_err++; $display("FAIL rand_pend c%0d: got %0d expected %0d", c, $signed(bus.PEND), m_pend); end
      if (bus.CNT_UPD !== 1'(m_upd)) begin n_err++; $display("FAIL rand_upd c%0d: got %b expected %0d", c, bus.CNT_UPD, m_upd); end
      if (bus.PEND_OVF !== 1'(m_ovf)) begin n_err++; $display("FAIL rand_ovf c%0d: got %b expected %0d", c, bus.PEND_OVF, m_ovf); end
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    test_reset();
    test_width();
    test_service();
    test_wrap();
    test_saturation();
    test_ccduz();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
